// File: rtl/stream_mux_rr_pkg.sv
// Shared constants for the round-robin stream multiplexer.
package stream_mux_rr_pkg;

    // Packet state encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    // Arbitration modes
    localparam int unsigned MODE_RR    = 0;
    localparam int unsigned MODE_FIXED = 1;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational arbiter: round-robin starting at ptr, or fixed lowest-index priority.
module rr_arbiter
    import stream_mux_rr_pkg::*;
#(
    parameter int unsigned NUM_CH    = 16,
    parameter int unsigned SEL_WIDTH = 4,
    parameter int unsigned MODE      = 0
) (
    input  logic [NUM_CH-1:0]    req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic                 grant_valid,
    output logic [SEL_WIDTH-1:0] grant_idx
);

    logic [2*NUM_CH-1:0] req2;
    logic [NUM_CH-1:0]   rot;
    int unsigned         base;
    int unsigned         off;
    int unsigned         sum;

    // Rotate requests so the search start sits at bit 0, then take the lowest set bit
    always_comb begin
        req2        = {req, req};
        base        = (MODE == MODE_FIXED) ? 32'd0 : 32'(ptr);
        rot         = NUM_CH'(req2 >> base);
        grant_valid = 1'b0;
        off         = 32'd0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                grant_valid = 1'b1;
                off         = 32'(i);
            end
        end
        sum = base + off;
        if (sum >= NUM_CH) begin
            sum = sum - NUM_CH;
        end
        grant_idx = SEL_WIDTH'(sum);
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel packet-locked stream multiplexer with a one-deep registered output.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_CH     = 16,
    parameter int unsigned SEL_WIDTH  = 4,
    parameter int unsigned MODE       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_last,
    output logic [NUM_CH-1:0]            in_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_last,
    output logic [SEL_WIDTH-1:0]         out_ch,
    input  logic                         out_ready
);

    logic [0:0]           state;
    logic [0:0]           state_nxt;
    logic [SEL_WIDTH-1:0] lock_ch;
    logic [SEL_WIDTH-1:0] lock_nxt;
    logic [SEL_WIDTH-1:0] ptr;
    logic [SEL_WIDTH-1:0] ptr_nxt;
    logic                 load_en;
    logic                 grant_valid;
    logic [SEL_WIDTH-1:0] grant_idx;
    logic                 sel_valid;
    logic [SEL_WIDTH-1:0] sel;
    logic                 accept;
    logic                 acc_last;
    logic [DATA_WIDTH-1:0] acc_data;

    rr_arbiter #(
        .NUM_CH    (NUM_CH),
        .SEL_WIDTH (SEL_WIDTH),
        .MODE      (MODE)
    ) u_arb (
        .req         (in_valid),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign load_en   = !out_valid || out_ready;
    assign sel_valid = (state == ST_LOCK) || grant_valid;
    assign sel       = (state == ST_LOCK) ? lock_ch : grant_idx;
    assign accept    = |(in_valid & in_ready);
    assign acc_last  = in_last[32'(sel) +: 1];
    assign acc_data  = in_data[32'(sel) * DATA_WIDTH +: DATA_WIDTH];

    // One-hot ready toward the selected channel; nothing is accepted during reset
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            in_ready[i] = !rst && load_en && sel_valid && (sel == SEL_WIDTH'(i));
        end
    end

    // Packet lock and round-robin pointer next-state
    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_ch;
        ptr_nxt   = ptr;
        if (accept) begin
            if (acc_last) begin
                state_nxt = ST_IDLE;
                if (MODE == MODE_RR) begin
                    ptr_nxt = (32'(sel) == NUM_CH - 1) ? '0 : sel + SEL_WIDTH'(1);
                end
            end else begin
                state_nxt = ST_LOCK;
                lock_nxt  = sel;
            end
        end
    end

    // State, lock channel and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            lock_ch <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_nxt;
            lock_ch <= lock_nxt;
            ptr     <= ptr_nxt;
        end
    end

    // Output beat register: load on accept, drain when the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else if (load_en) begin
            out_valid <= accept;
            if (accept) begin
                out_data <= acc_data;
                out_last <= acc_last;
                out_ch   <= sel;
            end
        end
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel stream multiplexer: the successor to the team's combinational select-driven muxes, with internal arbitration instead of an external select. Selects one of NUM_CH valid/ready input streams via round-robin or fixed-priority arbitration and locks to that channel for a whole packet, delimited by `last`. Presents the chosen beat through a one-deep registered output with backpressure. Sits between multiple producer datapaths and a single shared consumer.

## Interface
- DATA_WIDTH, 8, payload bits per beat
- NUM_CH, 16, number of input channels (≥1, need not be a power of two)
- SEL_WIDTH, 4, width of channel index; must equal max(1, $clog2(NUM_CH))
- MODE, 0, arbitration: 0 = round-robin, 1 = fixed priority (lowest index wins)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  NUM_CH  per-channel beat valid
- in_data  in  NUM_CH*DATA_WIDTH  flattened payloads; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_last  in  NUM_CH  per-channel end-of-packet flag
- in_ready  out  NUM_CH  per-channel accept (combinational)
- out_valid  out  1  registered beat valid
- out_data  out  DATA_WIDTH  registered payload
- out_last  out  1  registered end-of-packet
- out_ch  out  SEL_WIDTH  source channel of current output beat
- out_ready  in  1  consumer accept

## Operation
- States: IDLE (no packet in progress), LOCK (mid-packet, bound to `lock_ch`).
- load_en = !out_valid | out_ready.
- sel: in LOCK = lock_ch; in IDLE = arbitration winner among asserted in_valid; none if no valid.
- in_ready[i] = load_en & (sel exists) & (i == sel). At most one in_ready high.
- Beat accepted on channel i when in_valid[i] & in_ready[i]; output register loads data, last, out_ch = i, out_valid = 1.
- If load_en and no acceptance: out_valid clears when out_ready drains it; otherwise holds.
- Transitions: IDLE→LOCK on accepted beat with last = 0 (lock_ch = i); LOCK→IDLE on accepted beat with last = 1; IDLE stays IDLE on accepted single-beat packet.
- Round-robin: pointer ptr (reset 0); search order ptr, ptr+1, …, NUM_CH-1, 0, …, ptr-1. On accepting a last beat from channel g, ptr ← g+1, wrapping NUM_CH-1 → 0. Fixed priority: ptr unused, lowest asserted index wins.
- Locked channel deasserting in_valid mid-packet: remain LOCK, serve no other channel (bubbles allowed).
- Output held stable (data, last, ch) while out_valid & !out_ready.

## Timing
- Reset values: out_valid 0, out_data 0, out_last 0, out_ch 0, state IDLE, lock_ch 0, ptr 0.
- rst mid-packet: output beat discarded, state IDLE, ptr 0, next cycle in_ready follows IDLE arbitration.
- Latency: accept on edge k → out_valid visible after edge k.
- Throughput: 1 beat/cycle with out_ready held high; no bubble between packets of different channels.
- Simultaneous drain and load in the same cycle: new beat replaces old, out_valid stays 1.
- in_ready depends combinationally on out_valid, out_ready, in_valid, state; no combinational path from in_data to any output.

## Structure
- Shared package/include: state encodings (IDLE, LOCK), MODE constants (MODE_RR, MODE_FIXED).
- Sub-module `rr_arbiter` (params NUM_CH, SEL_WIDTH, MODE): inputs req, ptr; outputs grant_valid, grant_idx. Pure combinational; pointer register lives in top.
- Payload select by indexed part-select on in_data; no mux tree instances.

## Test plan
- Reset: assert rst 2 cycles with all in_valid high → out_valid 0, out_ch 0, all in_ready 0 during reset; first grant afterwards is ch 0 (RR).
- RR fairness: NUM_CH=4, all channels send single-beat packets continuously, out_ready=1 → out_ch sequence 0,1,2,3,0,1,… with out_valid high every cycle.
- Packet lock: ch 2 sends 3-beat packet (data 0xA1,0xA2,0xA3, last on third), ch 0 valid throughout → outputs A1,A2,A3 from ch 2 consecutively, then ch 0; ch 2 gap mid-packet leaves ch 0 unserved.
- Backpressure: out_ready low 3 cycles with out_valid=1, data 0x5C → out_data/out_last/out_ch unchanged, all in_ready 0; out_ready high → next beat loads same cycle.
- Wrap/non-power-of-two: NUM_CH=5, ptr at 4, requests on ch 1 and 4 → ch 4 granted, then ch 1 (ptr wraps to 0).
- MODE=1 and reset mid-packet: ch 3 and ch 1 valid → ch 1 wins always; rst during ch 1 packet → out_valid 0 next cycle, IDLE, ch 1 re-arbitrates.
